// File: rtl/apb_requester.sv
// APB initiator: one valid/ready command in, one APB transfer out, one response back.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_REQ_TIMEOUT_EN.
module apb_requester #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t r_state;

`ifdef APB_REQ_TIMEOUT_EN
  logic [15:0] r_wait;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state   <= S_IDLE;
      cmd_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
      r_wait    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          r_state <= S_ACCESS;
`ifdef APB_REQ_TIMEOUT_EN
          r_wait  <= '0;
`endif
        end
        S_ACCESS: begin
          // A completing pready always beats the timeout limit in the same cycle.
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end
`ifdef APB_REQ_TIMEOUT_EN
          else if (r_wait == 16'(TIMEOUT_CYCLES - 1)) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: directed scenarios plus randomized transfers against a
// memory-backed APB slave and an independent reference memory.
module tb_apb_requester;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] slv_mem [8];
  logic [DW-1:0] ref_mem [8];

  apb_requester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with it idle.
  task automatic do_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input bit err, input int dly, input bit hold);
    logic [DW-1:0] exp_rd;
    int idx;
    idx = int'(a[4:2]);
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    pready = 1'($urandom_range(0, 1));
    @(negedge pclk);
    if (!hold) cmd_valid = 1'b0;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_cmd_ready", cmd_ready, 0);
    chk("setup_paddr", paddr, a);
    chk("setup_pwrite", pwrite, w);
    chk("setup_pwdata", pwdata, d);
    @(negedge pclk);
    pready = 1'b0;
    chk("access_psel", psel, 1);
    chk("access_penable", penable, 1);
    chk("access_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < waits; i++) begin
      @(negedge pclk);
      chk("wait_penable", penable, 1);
      chk("wait_paddr", paddr, a);
      chk("wait_pwdata", pwdata, d);
      chk("wait_rsp_valid", rsp_valid, 0);
    end
    pready = 1'b1; pslverr = err;
    prdata = w ? ($urandom() | 32'h1) : slv_mem[idx];
    if (w && !err) slv_mem[idx] = pwdata;
    exp_rd = w ? '0 : ref_mem[idx];
    if (w && !err) ref_mem[idx] = d;
    @(negedge pclk);
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom();
    chk("resp_valid", rsp_valid, 1);
    chk("resp_psel", psel, 0);
    chk("resp_penable", penable, 0);
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk("resp_err", rsp_err, err);
    chk("resp_cmd_ready", cmd_ready, 0);
    for (int i = 0; i < dly; i++) begin
      pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1));
      @(negedge pclk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", rsp_err, err);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    pslverr = 1'b0;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
    chk("done_psel", psel, 0);
  endtask

  initial begin
    bit stuck_ok;
    for (int i = 0; i < 8; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end

    // Reset values
    @(negedge pclk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    preset = 1'b0;
    @(negedge pclk);

    // Zero-wait write; read with 3 waits; error read with 5-cycle backpressure
    do_txn(1'b1, 32'h8, 32'hDEADBEEF, 0, 1'b0, 0, 1'b0);
    slv_mem[3] = 32'hA5A50000; ref_mem[3] = 32'hA5A50000;
    do_txn(1'b0, 32'hC, 32'h0, 3, 1'b0, 0, 1'b0);
    do_txn(1'b0, 32'h14, 32'h0, 0, 1'b1, 5, 1'b0);
    chk("idle_paddr_retained", paddr, 32'h14);

    // Back-to-back with cmd_valid held
    do_txn(1'b1, 32'h0, 32'h11112222, 0, 1'b0, 0, 1'b1);
    do_txn(1'b1, 32'h10, 32'h33334444, 1, 1'b0, 0, 1'b1);
    do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0, 0, 1'b0);

    // Reset asserted mid-ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    pready = 1'b0;
    @(negedge pclk);
    chk("pre_rst_penable", penable, 1);
    #2 preset = 1'b1;
    #1;
    chk("async_rst_psel", psel, 0);
    chk("async_rst_penable", penable, 0);
    chk("async_rst_cmd_ready", cmd_ready, 1);
    @(negedge pclk);
    preset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_cmd_ready", cmd_ready, 1);
    end

    // Slave that never answers
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h18;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    pready = 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
    repeat (3) @(negedge pclk);
    chk("to_before_valid", rsp_valid, 0);
    chk("to_before_penable", penable, 1);
    @(negedge pclk);
    chk("to_valid", rsp_valid, 1);
    chk("to_err", rsp_err, 1);
    chk("to_rdata", rsp_rdata, 0);
    chk("to_psel", psel, 0);
`else
    stuck_ok = 1'b1;
    repeat (1000) begin
      @(negedge pclk);
      if (rsp_valid !== 1'b0 || penable !== 1'b1) stuck_ok = 1'b0;
    end
    chk("no_timeout_stuck", stuck_ok, 1);
    pready = 1'b1; prdata = slv_mem[6];
    @(negedge pclk);
    pready = 1'b0;
    chk("late_valid", rsp_valid, 1);
    chk("late_rdata", rsp_rdata, ref_mem[6]);
    chk("late_err", rsp_err, 0);
`endif
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("to_done_cmd_ready", cmd_ready, 1);

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      bit w;
      w = 1'($urandom_range(0, 1));
      do_txn(w, 32'($urandom_range(0, 7) * 4), $urandom(), int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
             (n != 39) && ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB initiator (master) that turns single-beat commands from an internal valid/ready command port into APB transfers.
- Drives psel/penable/paddr/pwrite/pwdata toward APB register slaves on the same pclk domain.
- Returns read data and the error status on a valid/ready response port.
- Used by on-chip controllers and test harnesses to program and read back APB register banks.

Parameters:
ADDR_W, 32, width of cmd_addr and paddr
DATA_W, 32, width of write and read data
TIMEOUT_CYCLES, 256, max ACCESS-phase wait before abort (used only with APB_REQ_TIMEOUT_EN); legal range 2..65535

Ports:
pclk  in  1  APB clock; all logic on rising edge
preset  in  1  asynchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  pslverr captured, or timeout abort
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  slave ready; tie to 1 for zero-wait slaves
pslverr  in  1  slave error; tie to 0 if unused

Behaviour:
- All outputs are registered. On preset: state = IDLE, cmd_ready = 1, psel/penable/pwrite = 0, paddr/pwdata = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Asserting preset mid-transfer drops psel/penable on the same edge and discards the command; no response is produced.
- FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On accept, latch cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP (exactly one cycle):
  - psel = 1, penable = 0.
  - Go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1.
  - Sample pready each cycle. On pready = 1:
    - capture rsp_rdata = (pwrite ? 0 : prdata) and rsp_err = pslverr;
    - deassert psel/penable;
    - go to RESP.
  - On pready = 0, stay in ACCESS.
- RESP:
  - rsp_valid = 1.
  - rsp_rdata/rsp_err are held stable until rsp_ready.
  - On handshake: rsp_valid = 0, go to IDLE.
- cmd_ready is 1 only in IDLE. There is one transfer outstanding at most; no command buffering.
- paddr/pwrite/pwdata are stable from SETUP through the final ACCESS cycle, and retain their last values while idle.
- Zero-wait latency, with the accept edge as cycle 0:
  - SETUP in cycle 1;
  - ACCESS in cycle 2;
  - rsp_valid in cycle 3;
  - next cmd_ready in cycle 4 if rsp_ready was high in cycle 3.
- Each wait state adds one cycle.
- Inputs pready/pslverr/prdata are ignored outside ACCESS.
- rsp_ready asserted while rsp_valid = 0 has no effect.
- cmd_valid may be held high across transfers. A new command is accepted only in IDLE, and ordering is strict.

Optional Feature:
- Macro: APB_REQ_TIMEOUT_EN.
- With the macro defined:
  - a wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready = 0;
  - when the count reaches TIMEOUT_CYCLES, the transfer is aborted: psel/penable drop, rsp_rdata = 0, rsp_err = 1, go to RESP;
  - if pready = 1 in the same cycle the limit is reached, the normal completion wins.
- Without the macro: no counter exists, and ACCESS waits for pready indefinitely.

Test Plan:
- Write: cmd write addr 0x8 data 0xDEADBEEF, pready = 1 -> psel high for cycles 1-2, penable high cycle 2 only, paddr = 0x8, pwdata = 0xDEADBEEF; rsp_valid cycle 3 with rsp_rdata = 0, rsp_err = 0.
- Read with waits: cmd read addr 0xC, pready low for 3 ACCESS cycles, then high with prdata = 0xA5A50000 -> penable high 4 cycles; rsp_rdata = 0xA5A50000 delivered 3 cycles later than the zero-wait case.
- Error plus backpressure: read 0x14, pslverr = 1 with pready; rsp_ready held low 5 cycles -> rsp_valid and rsp_err = 1 held stable for 5 cycles, cmd_ready = 0 throughout; IDLE after handshake.
- Back-to-back: cmd_valid held high with writes to 0x0, 0x10, then a read of 0x10 -> three transfers in order, each separated by IDLE, and the read returns the value written to 0x10.
- Reset mid-ACCESS: preset pulsed while penable = 1 -> psel/penable = 0 immediately (asynchronously), no rsp_valid, cmd_ready = 1 after release.
- Timeout (APB_REQ_TIMEOUT_EN, TIMEOUT_CYCLES = 4): pready held 0 -> abort after 4 wait cycles, rsp_err = 1, rsp_rdata = 0; without the macro, rsp_valid stays 0 for 1000 cycles.
